branch_unit: RTL and testbench

Registered, handshaked branch resolution unit for the NPC execute stage; the parametrised successor of the combinational branch comparator. Accepts one control-transfer op per cycle (conditional branch, JAL, JALR) with operands, PC, immediate and the frontend's prediction. One cycle later it presents taken/target, the corrected next PC, link address and a mispredict flag. It uses a valid/ready pipeline register with flush, and optional performance counters.

---
 rtl/branch_unit_pkg.sv | 19 +
 rtl/branch_cmp.sv | 29 ++
 rtl/branch_unit.sv | 104 ++++++++++
 tb/tb_branch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: shared encodings for the branch unit (control-transfer kinds, branch conditions, stage states)
package branch_unit_pkg;
    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_COND = 2'b01;
    localparam logic [1:0] KIND_JAL  = 2'b10;
    localparam logic [1:0] KIND_JALR = 2'b11;

    localparam logic [2:0] BRANCH_BEQ     = 3'b000;
    localparam logic [2:0] BRANCH_BNE     = 3'b001;
    localparam logic [2:0] BRANCH_UNTAKEN = 3'b010;
    localparam logic [2:0] BRANCH_BLT     = 3'b100;
    localparam logic [2:0] BRANCH_BGE     = 3'b101;
    localparam logic [2:0] BRANCH_BLTU    = 3'b110;
    localparam logic [2:0] BRANCH_BGEU    = 3'b111;

    typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/branch_cmp.sv
// branch_cmp: combinational branch condition evaluator; a keyed select on brop whose default
// (including 010/011) is not-taken.
module branch_cmp
    import branch_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] data_a,
    input  logic [XLEN-1:0] data_b,
    input  logic [2:0]      brop,
    output logic            taken
);
    logic eq, lt, ltu;

    assign eq  = data_a == data_b;
    assign lt  = $signed(data_a) < $signed(data_b);
    assign ltu = data_a < data_b;

    always_comb begin
        taken = 1'b0;
        taken = brop == BRANCH_UNTAKEN ? 1'b0 :
                brop == BRANCH_BEQ     ? eq   :
                brop == BRANCH_BNE     ? !eq  :
                brop == BRANCH_BLT     ? lt   :
                brop == BRANCH_BGE     ? !lt  :
                brop == BRANCH_BLTU    ? ltu  :
                brop == BRANCH_BGEU    ? !ltu : 1'b0;
    end
endmodule

// File: rtl/branch_unit.sv
// branch_unit: registered valid/ready branch resolution with flush.
// Optional performance counters enabled by defining BRANCH_STATS_EN.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_kind,
    input  logic [2:0]      in_brop,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_pred_taken,
    input  logic [XLEN-1:0] in_pred_target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_next_pc,
    output logic [XLEN-1:0] out_link,
    output logic            out_mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
`endif
);
    state_t          state, state_nx;
    logic            cmp_taken, taken, mispredict, accept, is_jalr;
    logic [XLEN-1:0] sum, target, link, next_pc;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .data_a(in_rs1),
        .data_b(in_rs2),
        .brop  (in_brop),
        .taken (cmp_taken)
    );

    assign is_jalr    = in_kind == KIND_JALR;
    assign taken      = (in_kind == KIND_COND & cmp_taken) | in_kind == KIND_JAL | is_jalr;
    assign sum        = (is_jalr ? in_rs1 : in_pc) + in_imm;
    assign target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    assign link       = in_pc + XLEN'(4);
    assign next_pc    = taken ? target : link;
    assign mispredict = (taken != in_pred_taken) | (taken & in_pred_taken & target != in_pred_target);

    assign out_valid = state == FULL;
    assign in_ready  = !flush & (!out_valid | out_ready);
    assign accept    = in_valid & in_ready;

    always_comb begin
        state_nx = state;
        state_nx = flush            ? EMPTY :
                   accept           ? FULL  :
                   out_ready        ? EMPTY : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= EMPTY;
            out_taken      <= 1'b0;
            out_target     <= '0;
            out_next_pc    <= '0;
            out_link       <= '0;
            out_mispredict <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_taken      <= taken;
                out_target     <= target;
                out_next_pc    <= next_pc;
                out_link       <= link;
                out_mispredict <= mispredict;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [1:0] kind_q;
    logic       count;

    // a result killed by flush is never counted, even if the consumer was ready
    assign count = out_valid & out_ready & !flush & kind_q != KIND_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kind_q           <= KIND_NONE;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept) kind_q <= in_kind;
            if (count) stat_branches <= stat_branches + 1'b1;
            if (count & out_mispredict) stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed self-checking bench for branch_unit (XLEN=32).
module tb_branch_unit;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready, in_pred_taken = 0;
    logic [1:0]  in_kind = 0;
    logic [2:0]  in_brop = 0;
    logic [31:0] in_rs1 = 0, in_rs2 = 0, in_pc = 0, in_imm = 0, in_pred_target = 0;
    logic        out_valid, out_ready = 1, out_taken, out_mispredict;
    logic [31:0] out_target, out_next_pc, out_link;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts, sb0, sm0;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_brop(in_brop), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_next_pc(out_next_pc),
        .out_link(out_link), .out_mispredict(out_mispredict)
`ifdef BRANCH_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [1:0] k, input logic [2:0] b, input logic [31:0] r1, r2, pc, imm,
                          input logic pt, input logic [31:0] ptg);
        in_valid = 1; in_kind = k; in_brop = b; in_rs1 = r1; in_rs2 = r2;
        in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptg;
    endtask

    task automatic send(input logic [1:0] k, input logic [2:0] b, input logic [31:0] r1, r2, pc, imm,
                        input logic pt, input logic [31:0] ptg);
        set_op(k, b, r1, r2, pc, imm, pt, ptg);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic res(input string tag, input logic tk, input logic [31:0] tg, np, ln, input logic mp);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".taken"}, out_taken, tk);
        chk({tag, ".target"}, out_target, tg);
        chk({tag, ".next_pc"}, out_next_pc, np);
        chk({tag, ".link"}, out_link, ln);
        chk({tag, ".mispredict"}, out_mispredict, mp);
    endtask

    initial begin
        #2;
        chk("rst.valid", out_valid, 0);
        chk("rst.taken", out_taken, 0);
        chk("rst.target", out_target, 0);
        chk("rst.next_pc", out_next_pc, 0);
        chk("rst.link", out_link, 0);
        chk("rst.mispredict", out_mispredict, 0);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        send(2'b01, 3'b100, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h10, 0, 0);
        res("blt", 1, 32'h80000010, 32'h80000010, 32'h80000004, 1);
        send(2'b01, 3'b110, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h10, 0, 0);
        res("bltu", 0, 32'h80000010, 32'h80000004, 32'h80000004, 0);
        send(2'b11, 3'b000, 32'h80001003, 0, 32'h80000100, 32'h4, 1, 32'h80001006);
        res("jalr_ok", 1, 32'h80001006, 32'h80001006, 32'h80000104, 0);
        send(2'b11, 3'b000, 32'h80001003, 0, 32'h80000100, 32'h4, 1, 32'h80001008);
        res("jalr_bad", 1, 32'h80001006, 32'h80001006, 32'h80000104, 1);
        send(2'b01, 3'b000, 32'h5, 32'h5, 32'hFFFFFFFC, 32'h8, 1, 32'h4);
        res("wrap", 1, 32'h4, 32'h4, 32'h0, 0);
        send(2'b00, 3'b000, 32'h5, 32'h5, 32'h1000, 32'h20, 1, 32'h1020);
        res("none_pt", 0, 32'h1020, 32'h1004, 32'h1004, 1);
        send(2'b01, 3'b001, 32'h7, 32'h7, 32'h2000, 32'h40, 0, 0);
        res("bne_eq", 0, 32'h2040, 32'h2004, 32'h2004, 0);
        send(2'b01, 3'b101, 32'h1, 32'hFFFFFFFF, 32'h2000, 32'hFFFFFFF0, 1, 32'h1FF0);
        res("bge", 1, 32'h1FF0, 32'h1FF0, 32'h2004, 0);
        send(2'b01, 3'b010, 32'h1, 32'h1, 32'h2000, 32'h8, 0, 0);
        res("untaken", 0, 32'h2008, 32'h2004, 32'h2004, 0);
        send(2'b01, 3'b111, 32'h3, 32'h80000000, 32'h3000, 32'h8, 1, 32'h3008);
        res("bgeu", 0, 32'h3008, 32'h3004, 32'h3004, 1);
        @(posedge clk); #1;
        chk("drain.valid", out_valid, 0);

        out_ready = 0;
        send(2'b10, 3'b000, 0, 0, 32'h100, 32'h20, 1, 32'h120);
        chk("bp.in_ready", in_ready, 0);
        set_op(2'b10, 3'b000, 0, 0, 32'h200, 32'h40, 1, 32'h240);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_target", out_target, 32'h120);
            chk("bp.hold_valid", out_valid, 1);
            chk("bp.hold_ready", in_ready, 0);
        end
        out_ready = 1;
        #1 chk("bp.ready_up", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        res("bp.second", 1, 32'h240, 32'h240, 32'h204, 0);
        @(posedge clk); #1;
        chk("bp.empty", out_valid, 0);

        out_ready = 0;
        send(2'b10, 3'b000, 0, 0, 32'h300, 32'h10, 0, 0);
`ifdef BRANCH_STATS_EN
        sb0 = stat_branches; sm0 = stat_mispredicts;
`endif
        set_op(2'b10, 3'b000, 0, 0, 32'h400, 32'h10, 0, 0);
        flush = 1; out_ready = 1;
        #1 chk("fl.in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("fl.valid", out_valid, 0);
        chk("fl.not_captured", out_target, 32'h310);
`ifdef BRANCH_STATS_EN
        chk("fl.stat_b", stat_branches, sb0);
        chk("fl.stat_m", stat_mispredicts, sm0);
`endif
        @(posedge clk); #1;
        chk("fl.still_empty", out_valid, 0);

        out_ready = 0;
        send(2'b10, 3'b000, 0, 0, 32'h500, 32'h10, 0, 0);
        chk("ar.full", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("ar.valid", out_valid, 0);
        chk("ar.taken", out_taken, 0);
        chk("ar.target", out_target, 0);
        chk("ar.link", out_link, 0);
        chk("ar.next_pc", out_next_pc, 0);
`ifdef BRANCH_STATS_EN
        chk("ar.stat_b", stat_branches, 0);
        chk("ar.stat_m", stat_mispredicts, 0);
`endif
        @(negedge clk); rst_n = 1; out_ready = 1;
        @(posedge clk); #1;

`ifdef BRANCH_STATS_EN
        send(2'b01, 3'b000, 1, 1, 32'h100, 8, 1, 32'h108);
        send(2'b01, 3'b000, 1, 2, 32'h100, 8, 1, 32'h108);
        send(2'b10, 3'b000, 0, 0, 32'h100, 8, 1, 32'h108);
        send(2'b00, 3'b000, 0, 0, 32'h100, 8, 0, 0);
        send(2'b11, 3'b000, 32'h200, 0, 32'h100, 8, 1, 32'h208);
        send(2'b11, 3'b000, 32'h200, 0, 32'h100, 8, 0, 0);
        @(posedge clk); #1;
        chk("st.branches", stat_branches, 5);
        chk("st.mispredicts", stat_mispredicts, 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
